// File: rtl/ssd1306_pkg.sv
// ssd1306_pkg: shared definitions for the SSD1306 SPI receiver.
//   - Opcodes the decoder acts on.
//   - Address-mode and decoder-state enums.
//   - cmd_arg_cnt(): how many argument bytes a command consumes.
package ssd1306_pkg;

    localparam logic [7:0] CMD_SET_MODE    = 8'h20;
    localparam logic [7:0] CMD_COL_ADDR    = 8'h21;
    localparam logic [7:0] CMD_PAGE_ADDR   = 8'h22;
    localparam logic [7:0] CMD_CONTRAST    = 8'h81;
    localparam logic [7:0] CMD_CHARGE_PUMP = 8'h8D;
    localparam logic [7:0] CMD_MUX_RATIO   = 8'hA8;
    localparam logic [7:0] CMD_DISP_OFFSET = 8'hD3;
    localparam logic [7:0] CMD_CLK_DIV     = 8'hD5;
    localparam logic [7:0] CMD_PRECHARGE   = 8'hD9;
    localparam logic [7:0] CMD_COM_PINS    = 8'hDA;
    localparam logic [7:0] CMD_VCOMH       = 8'hDB;

    typedef enum logic [1:0] {
        HORIZ = 2'd0,
        VERT  = 2'd1,
        PAGE  = 2'd2
    } e_addr_mode;

    typedef enum logic [1:0] {
        S_CMD  = 2'd0,
        S_ARG1 = 2'd1,
        S_ARG2 = 2'd2
    } e_dec_state;

    // Number of argument bytes following an opcode (0 = single-byte command).
    function automatic logic [1:0] cmd_arg_cnt(input logic [7:0] op);
        case (op)
            CMD_COL_ADDR, CMD_PAGE_ADDR:                  return 2'd2;
            CMD_SET_MODE, CMD_CONTRAST, CMD_CHARGE_PUMP,
            CMD_MUX_RATIO, CMD_DISP_OFFSET, CMD_CLK_DIV,
            CMD_PRECHARGE, CMD_COM_PINS, CMD_VCOMH:       return 2'd1;
            default:                                      return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/ssd1306_spi_deserializer.sv
// ssd1306_spi_deserializer: oversampling front end of the SSD1306 SPI link.
//   Synchronises the pins, detects SPI clock rising edges, shifts bytes in
//   MSB first and reports each completed byte.
// Optional feature: define SSD1306_RX_FRAME_CHECK_EN to flag CSN rising mid-byte.
// Ports:
//   i_clk, i_reset        system clock, synchronous active-high reset
//   i_rstn/i_csn/i_dc/i_sclk/i_mosi  raw SPI pins
//   o_rst                 combined reset (i_reset or synchronised rstn low)
//   o_done/o_done_byte/o_done_dc  combinational: byte completes this cycle
//   o_byte/o_byte_is_data/o_byte_stb  registered byte outputs
//   o_frame_err           sticky partial-byte flag
module ssd1306_spi_deserializer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rstn,
    input  logic       i_csn,
    input  logic       i_dc,
    input  logic       i_sclk,
    input  logic       i_mosi,
    output logic       o_rst,
    output logic       o_done,
    output logic [7:0] o_done_byte,
    output logic       o_done_dc,
    output logic [7:0] o_byte,
    output logic       o_byte_is_data,
    output logic       o_byte_stb,
    output logic       o_frame_err
);

    logic [SYNC_STAGES-1:0] r_rstn_s, r_csn_s, r_dc_s, r_sclk_s, r_mosi_s;
    logic                   r_sclk_prev;
    logic [6:0]             r_shift;
    logic [2:0]             r_bit_cnt;

    logic w_csn, w_rise, w_shift_en;

    // Synchronisers run on i_reset only so the rstn pin itself is observable.
    // rstn syncs reset to 0: the decoder stays in reset until the pin is seen high.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rstn_s    <= '0;
            r_csn_s     <= '1;
            r_dc_s      <= '0;
            r_sclk_s    <= '0;
            r_mosi_s    <= '0;
            r_sclk_prev <= 1'b0;
        end else begin
            r_rstn_s    <= {r_rstn_s[SYNC_STAGES-2:0], i_rstn};
            r_csn_s     <= {r_csn_s[SYNC_STAGES-2:0],  i_csn};
            r_dc_s      <= {r_dc_s[SYNC_STAGES-2:0],   i_dc};
            r_sclk_s    <= {r_sclk_s[SYNC_STAGES-2:0], i_sclk};
            r_mosi_s    <= {r_mosi_s[SYNC_STAGES-2:0], i_mosi};
            r_sclk_prev <= r_sclk_s[SYNC_STAGES-1];
        end
    end

    assign o_rst       = i_reset | ~r_rstn_s[SYNC_STAGES-1];
    assign w_csn       = r_csn_s[SYNC_STAGES-1];
    assign w_rise      = r_sclk_s[SYNC_STAGES-1] & ~r_sclk_prev;
    assign w_shift_en  = w_rise & ~w_csn & ~o_rst;
    assign o_done      = w_shift_en & (r_bit_cnt == 3'd7);
    assign o_done_byte = {r_shift, r_mosi_s[SYNC_STAGES-1]};
    assign o_done_dc   = r_dc_s[SYNC_STAGES-1];

    always_ff @(posedge i_clk) begin
        if (o_rst) begin
            r_shift        <= '0;
            r_bit_cnt      <= '0;
            o_byte         <= '0;
            o_byte_is_data <= 1'b0;
            o_byte_stb     <= 1'b0;
        end else begin
            o_byte_stb <= o_done;
            if (o_done) begin
                o_byte         <= o_done_byte;
                o_byte_is_data <= o_done_dc;
            end
            // A deselected link drops any partial byte.
            if (w_csn) begin
                r_bit_cnt <= '0;
            end else if (w_shift_en) begin
                r_shift   <= {r_shift[5:0], r_mosi_s[SYNC_STAGES-1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
        end
    end

`ifdef SSD1306_RX_FRAME_CHECK_EN
    // Cleared by i_reset only; a display reset must not hide a framing fault.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_frame_err <= 1'b0;
        end else if (w_csn && (r_bit_cnt != 3'd0)) begin
            o_frame_err <= 1'b1;
        end
    end
`else
    assign o_frame_err = 1'b0;
`endif

endmodule

// File: rtl/ssd1306_spi_receiver.sv
// ssd1306_spi_receiver: SSD1306 4-wire SPI receiver and framebuffer write generator.
//   Deserialises bytes, decodes addressing commands and tracks the column/page
//   pointer, emitting one framebuffer write per data byte.
// Optional feature: SSD1306_RX_FRAME_CHECK_EN enables frame_err_out.
// Ports:
//   clk_in, reset_in                     system clock, synchronous active-high reset
//   oled_rstn_in/csn/dc/clk/mosi_in      SPI pins (mode 0, MSB first)
//   byte_out/byte_is_data_out/byte_stb_out  last received byte and its dc value
//   fb_col_out/fb_page_out/fb_data_out/fb_write_stb_out  framebuffer write
//   frame_err_out                        sticky CSN-mid-byte flag
module ssd1306_spi_receiver
    import ssd1306_pkg::*;
#(
    parameter int COLS        = 128,
    parameter int PAGES       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic                     oled_rstn_in,
    input  logic                     oled_csn_in,
    input  logic                     oled_dc_in,
    input  logic                     oled_clk_in,
    input  logic                     oled_mosi_in,
    output logic [7:0]               byte_out,
    output logic                     byte_is_data_out,
    output logic                     byte_stb_out,
    output logic [$clog2(COLS)-1:0]  fb_col_out,
    output logic [$clog2(PAGES)-1:0] fb_page_out,
    output logic [7:0]               fb_data_out,
    output logic                     fb_write_stb_out,
    output logic                     frame_err_out
);

    localparam int CW = $clog2(COLS);
    localparam int PW = $clog2(PAGES);

    logic       w_rst, w_done, w_done_dc;
    logic [7:0] w_byte;

    ssd1306_spi_deserializer #(.SYNC_STAGES(SYNC_STAGES)) u_deser (
        .i_clk          (clk_in),
        .i_reset        (reset_in),
        .i_rstn         (oled_rstn_in),
        .i_csn          (oled_csn_in),
        .i_dc           (oled_dc_in),
        .i_sclk         (oled_clk_in),
        .i_mosi         (oled_mosi_in),
        .o_rst          (w_rst),
        .o_done         (w_done),
        .o_done_byte    (w_byte),
        .o_done_dc      (w_done_dc),
        .o_byte         (byte_out),
        .o_byte_is_data (byte_is_data_out),
        .o_byte_stb     (byte_stb_out),
        .o_frame_err    (frame_err_out)
    );

    e_dec_state    r_state, w_state_nxt;
    e_addr_mode    r_mode, w_mode_nxt;
    logic [7:0]    r_cmd, w_cmd_nxt;
    logic [7:0]    r_arg, w_arg_nxt;
    logic [CW-1:0] r_col, r_col_start, r_col_end;
    logic [CW-1:0] w_col_nxt, w_col_start_nxt, w_col_end_nxt;
    logic [PW-1:0] r_page, r_page_start, r_page_end;
    logic [PW-1:0] w_page_nxt, w_page_start_nxt, w_page_end_nxt;
    logic [7:0]    w_col8;
    logic [CW-1:0] w_col_lo, w_col_hi;
    logic [PW-1:0] w_page_lo, w_page_hi;
    logic          w_wr;

    assign w_wr = w_done & w_done_dc;

    always_ff @(posedge clk_in) begin
        if (w_rst) r_state <= S_CMD;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_mode_nxt       = r_mode;
        w_cmd_nxt        = r_cmd;
        w_arg_nxt        = r_arg;
        w_col_nxt        = r_col;
        w_col_start_nxt  = r_col_start;
        w_col_end_nxt    = r_col_end;
        w_page_nxt       = r_page;
        w_page_start_nxt = r_page_start;
        w_page_end_nxt   = r_page_end;
        w_col8           = 8'(r_col);
        // Range arguments are truncated to the pointer width; end < start collapses.
        w_col_lo         = CW'(r_arg);
        w_col_hi         = CW'(w_byte);
        w_page_lo        = PW'(r_arg);
        w_page_hi        = PW'(w_byte);
        if (w_col_hi < w_col_lo)   w_col_hi  = w_col_lo;
        if (w_page_hi < w_page_lo) w_page_hi = w_page_lo;

        if (w_wr) begin
            // Data bytes advance the pointer only; decoder state is untouched.
            case (r_mode)
                HORIZ: begin
                    if (r_col == r_col_end) begin
                        w_col_nxt  = r_col_start;
                        w_page_nxt = (r_page == r_page_end) ? r_page_start : r_page + PW'(1);
                    end else begin
                        w_col_nxt = r_col + CW'(1);
                    end
                end
                VERT: begin
                    if (r_page == r_page_end) begin
                        w_page_nxt = r_page_start;
                        w_col_nxt  = (r_col == r_col_end) ? r_col_start : r_col + CW'(1);
                    end else begin
                        w_page_nxt = r_page + PW'(1);
                    end
                end
                default: begin
                    w_col_nxt = (r_col == CW'(COLS-1)) ? '0 : r_col + CW'(1);
                end
            endcase
        end else if (w_done) begin
            case (r_state)
                S_CMD: begin
                    if (w_byte[7:4] == 4'h0) begin
                        w_col_nxt = CW'({w_col8[7:4], w_byte[3:0]});
                    end else if (w_byte[7:4] == 4'h1) begin
                        w_col_nxt = CW'({w_byte[3:0], w_col8[3:0]});
                    end else if (w_byte[7:3] == 5'b10110) begin
                        w_page_nxt = PW'(w_byte[2:0]);
                    end else if (cmd_arg_cnt(w_byte) != 2'd0) begin
                        w_cmd_nxt   = w_byte;
                        w_state_nxt = S_ARG1;
                    end
                end
                S_ARG1: begin
                    if (cmd_arg_cnt(r_cmd) == 2'd2) begin
                        w_arg_nxt   = w_byte;
                        w_state_nxt = S_ARG2;
                    end else begin
                        // Mode value 3 is reserved and leaves the mode alone.
                        if ((r_cmd == CMD_SET_MODE) && (w_byte[1:0] != 2'd3))
                            w_mode_nxt = e_addr_mode'(w_byte[1:0]);
                        w_state_nxt = S_CMD;
                    end
                end
                S_ARG2: begin
                    if (r_cmd == CMD_COL_ADDR) begin
                        w_col_start_nxt = w_col_lo;
                        w_col_end_nxt   = w_col_hi;
                        w_col_nxt       = w_col_lo;
                    end else begin
                        w_page_start_nxt = w_page_lo;
                        w_page_end_nxt   = w_page_hi;
                        w_page_nxt       = w_page_lo;
                    end
                    w_state_nxt = S_CMD;
                end
                default: w_state_nxt = S_CMD;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_rst) begin
            r_mode           <= PAGE;
            r_cmd            <= '0;
            r_arg            <= '0;
            r_col            <= '0;
            r_col_start      <= '0;
            r_col_end        <= CW'(COLS-1);
            r_page           <= '0;
            r_page_start     <= '0;
            r_page_end       <= PW'(PAGES-1);
            fb_col_out       <= '0;
            fb_page_out      <= '0;
            fb_data_out      <= '0;
            fb_write_stb_out <= 1'b0;
        end else begin
            r_mode           <= w_mode_nxt;
            r_cmd            <= w_cmd_nxt;
            r_arg            <= w_arg_nxt;
            r_col            <= w_col_nxt;
            r_col_start      <= w_col_start_nxt;
            r_col_end        <= w_col_end_nxt;
            r_page           <= w_page_nxt;
            r_page_start     <= w_page_start_nxt;
            r_page_end       <= w_page_end_nxt;
            fb_write_stb_out <= w_wr;
            // Write uses the address before this byte's increment.
            if (w_wr) begin
                fb_col_out  <= r_col;
                fb_page_out <= r_page;
                fb_data_out <= w_byte;
            end
        end
    end

endmodule

// File: tb/tb_ssd1306_spi_receiver.sv
module tb_ssd1306_spi_receiver;
    localparam int COLS = 128;
    localparam int PAGES = 8;
    localparam int SS = 2;
    localparam int HP = 4;   // SPI half period in clk_in cycles -> SPI clk = clk_in/8
    localparam int CW = $clog2(COLS);
    localparam int PW = $clog2(PAGES);
`ifdef SSD1306_RX_FRAME_CHECK_EN
    localparam logic FE = 1'b1;
`else
    localparam logic FE = 1'b0;
`endif

    logic clk_in = 0, reset_in = 1, oled_rstn_in = 1, oled_csn_in = 1;
    logic oled_dc_in = 0, oled_clk_in = 0, oled_mosi_in = 0;
    logic [7:0] byte_out, fb_data_out;
    logic byte_is_data_out, byte_stb_out, fb_write_stb_out, frame_err_out;
    logic [CW-1:0] fb_col_out;
    logic [PW-1:0] fb_page_out;

    always #5 clk_in = ~clk_in;

    ssd1306_spi_receiver #(.COLS(COLS), .PAGES(PAGES), .SYNC_STAGES(SS)) dut (
        .clk_in(clk_in), .reset_in(reset_in), .oled_rstn_in(oled_rstn_in),
        .oled_csn_in(oled_csn_in), .oled_dc_in(oled_dc_in), .oled_clk_in(oled_clk_in),
        .oled_mosi_in(oled_mosi_in), .byte_out(byte_out), .byte_is_data_out(byte_is_data_out),
        .byte_stb_out(byte_stb_out), .fb_col_out(fb_col_out), .fb_page_out(fb_page_out),
        .fb_data_out(fb_data_out), .fb_write_stb_out(fb_write_stb_out),
        .frame_err_out(frame_err_out)
    );

    int n_chk = 0, n_err = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Monitor: every byte strobe is captured with the write port and its cycle.
    typedef struct {
        logic [7:0] b; logic dc; logic w;
        logic [CW-1:0] col; logic [PW-1:0] page; logic [7:0] d; int cyc;
    } rec_t;
    rec_t q[$];
    rec_t mon_r;
    int cyc = 0, n_stray = 0, edge_cyc = 0;

    always @(posedge clk_in) cyc <= cyc + 1;
    always @(posedge clk_in) begin
        #1;
        if (byte_stb_out) begin
            mon_r.b = byte_out; mon_r.dc = byte_is_data_out; mon_r.w = fb_write_stb_out;
            mon_r.col = fb_col_out; mon_r.page = fb_page_out; mon_r.d = fb_data_out;
            mon_r.cyc = cyc;
            q.push_back(mon_r);
        end else if (fb_write_stb_out) begin
            n_stray++;
        end
    end

    // Reference model: pointer/range state plus a pending-argument list.
    int m_mode, m_col, m_page, m_cs, m_ce, m_ps, m_pe, m_op, m_need;
    int m_args[$];

    function automatic void model_reset();
        m_mode = 2; m_col = 0; m_page = 0;
        m_cs = 0; m_ce = COLS - 1; m_ps = 0; m_pe = PAGES - 1;
        m_need = 0; m_op = 0; m_args.delete();
    endfunction

    function automatic int n_args(input int op);
        if (op == 'h21 || op == 'h22) return 2;
        if (op == 'h20 || op == 'h81 || op == 'h8D || op == 'hA8 || op == 'hD3 ||
            op == 'hD5 || op == 'hD9 || op == 'hDA || op == 'hDB) return 1;
        return 0;
    endfunction

    function automatic void model_byte(input bit dc, input int b);
        int s, e;
        if (dc) begin
            if (m_mode == 0) begin
                if (m_col == m_ce) begin m_col = m_cs; m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % PAGES; end
                else m_col = (m_col + 1) % COLS;
            end else if (m_mode == 1) begin
                if (m_page == m_pe) begin m_page = m_ps; m_col = (m_col == m_ce) ? m_cs : (m_col + 1) % COLS; end
                else m_page = (m_page + 1) % PAGES;
            end else begin
                m_col = (m_col == COLS - 1) ? 0 : m_col + 1;
            end
            return;
        end
        if (m_need > 0) begin
            m_args.push_back(b);
            m_need--;
            if (m_need == 0) begin
                if (m_op == 'h20) begin
                    if ((m_args[0] % 4) != 3) m_mode = m_args[0] % 4;
                end else if (m_op == 'h21) begin
                    s = m_args[0] % COLS; e = m_args[1] % COLS; if (e < s) e = s;
                    m_cs = s; m_ce = e; m_col = s;
                end else if (m_op == 'h22) begin
                    s = m_args[0] % PAGES; e = m_args[1] % PAGES; if (e < s) e = s;
                    m_ps = s; m_pe = e; m_page = s;
                end
            end
            return;
        end
        if (b < 'h10) m_col = ((m_col / 16) * 16 + b) % COLS;
        else if (b < 'h20) m_col = ((b % 16) * 16 + m_col % 16) % COLS;
        else if (b >= 'hB0 && b <= 'hB7) m_page = (b % 8) % PAGES;
        else begin m_op = b; m_need = n_args(b); m_args.delete(); end
    endfunction

    // Pin drivers: all changes on the falling clk_in edge.
    task automatic spi_bits(input logic dc, input logic [7:0] b, input int nbits);
        if (oled_csn_in) begin
            @(negedge clk_in); oled_csn_in = 0;
            repeat (HP) @(negedge clk_in);
        end
        oled_dc_in = dc;
        for (int i = 7; i > 7 - nbits; i--) begin
            oled_mosi_in = b[i];
            repeat (HP) @(negedge clk_in);
            oled_clk_in = 1; edge_cyc = cyc;
            repeat (HP) @(negedge clk_in);
            oled_clk_in = 0;
        end
    endtask

    task automatic csn_high();
        @(negedge clk_in); oled_csn_in = 1;
        repeat (HP) @(negedge clk_in);
    endtask

    task automatic send(input logic dc, input logic [7:0] b);
        int w, ec, ep;
        rec_t r;
        ec = m_col; ep = m_page;
        spi_bits(dc, b, 8);
        w = 0;
        while (q.size() == 0 && w < 20) begin @(negedge clk_in); w++; end
        if (q.size() == 0) begin
            chk("stb_timeout", 0, 1);
        end else begin
            r = q.pop_front();
            chk("byte", r.b, b);
            chk("is_data", r.dc, dc);
            chk("wr_stb", r.w, dc);
            chk("stb_latency", r.cyc - edge_cyc, SS + 1);
            if (dc) begin
                chk("wr_col", r.col, ec);
                chk("wr_page", r.page, ep);
                chk("wr_data", r.d, b);
            end
        end
        model_byte(dc, b);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (5) @(negedge clk_in);
        reset_in = 0;
        repeat (SS + 3) @(negedge clk_in);
        chk("rst_byte", byte_out, 0);
        chk("rst_bstb", byte_stb_out, 0);
        chk("rst_isdata", byte_is_data_out, 0);
        chk("rst_wstb", fb_write_stb_out, 0);
        chk("rst_col", fb_col_out, 0);
        chk("rst_page", fb_page_out, 0);
        chk("rst_data", fb_data_out, 0);
        chk("rst_ferr", frame_err_out, 0);

        // Horizontal mode, three writes from the origin.
        send(0, 8'h20); send(0, 8'h00);
        send(1, 8'hAA); send(1, 8'h55); send(1, 8'hFF);
        chk("t1_col", fb_col_out, 2);
        chk("t1_page", fb_page_out, 0);
        csn_high();

        // Two-by-two window in the bottom-right corner.
        send(0, 8'h21); send(0, 8'h7E); send(0, 8'h7F);
        send(0, 8'h22); send(0, 8'h06); send(0, 8'h07);
        for (int i = 0; i < 5; i++) send(1, 8'(8'h10 + i));
        chk("t2_col", fb_col_out, 126);
        chk("t2_page", fb_page_out, 6);
        csn_high();

        // Page mode wrap at the last column.
        send(0, 8'h20); send(0, 8'h02);
        send(0, 8'hB3); send(0, 8'h0F); send(0, 8'h17);
        send(1, 8'h81); send(1, 8'h42);
        chk("t3_col", fb_col_out, 0);
        chk("t3_page", fb_page_out, 3);

        // Partial byte then a full data byte.
        spi_bits(1, 8'hA5, 5);
        csn_high();
        chk("t4_no_stb", q.size(), 0);
        send(1, 8'h3C);
        chk("t4_one_stb", q.size(), 0);
        chk("t4_ferr", frame_err_out, FE);
        csn_high();

        // Display reset with the second 0x21 argument still pending.
        send(0, 8'h21); send(0, 8'h10);
        @(negedge clk_in); oled_rstn_in = 0;
        repeat (SS + 4) @(negedge clk_in);
        chk("t5_rst_col", fb_col_out, 0);
        chk("t5_rst_byte", byte_out, 0);
        chk("t5_ferr_kept", frame_err_out, FE);
        oled_rstn_in = 1;
        repeat (SS + 4) @(negedge clk_in);
        model_reset();
        send(1, 8'h01);
        chk("t5_col", fb_col_out, 0);
        chk("t5_page", fb_page_out, 0);
        send(1, 8'h02);
        chk("t5_col_next", fb_col_out, 1);
        csn_high();

        // Randomised traffic against the model.
        for (int n = 0; n < 180; n++) begin
            logic dc;
            logic [7:0] b;
            int sel;
            dc = ($urandom_range(0, 9) < 6);
            sel = $urandom_range(0, 9);
            if (!dc && sel < 5) begin
                case (sel)
                    0: b = 8'h20;
                    1: b = 8'h21;
                    2: b = 8'h22;
                    3: b = 8'($urandom_range(0, 3));
                    default: b = 8'(8'hB0 + $urandom_range(0, 7));
                endcase
            end else begin
                b = 8'($urandom);
            end
            send(dc, b);
            if ($urandom_range(0, 15) == 0) csn_high();
        end

        repeat (10) @(negedge clk_in);
        chk("stray_wstb", n_stray, 0);
        chk("final_ferr", frame_err_out, FE);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
